output_port_vc_sched: RTL



---
 rtl/output_port_vc_sched_if.sv | 34 +++
 rtl/output_port_vc_sched.sv | 116 +++++++++++
 2 files changed

// File: rtl/output_port_vc_sched_if.sv
// Output-port VC scheduler bus.
// Groups the per-VC request/credit inputs, the link ready, and the grant, credit-consume
// and lock outputs of one output port.
//   master : request side (drives requests, credits, ready; observes grant/consume/lock)
//   slave  : scheduler side (output_port_vc_sched)
interface output_port_vc_sched_if #(
    parameter int unsigned VC_NUM             = 4,
    parameter int unsigned VC_NUM_IDX_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    parameter int unsigned VC_DEPTH_COUNTER_W = 1
);
    logic [VC_NUM-1:0]                    vc_req_vld_i;
    logic [VC_NUM-1:0]                    vc_req_tail_i;
    logic [VC_NUM*VC_DEPTH_COUNTER_W-1:0] vc_credit_counter_i;
    logic                                 out_ready_i;
    logic                                 grant_vld_o;
    logic [VC_NUM_IDX_W-1:0]              grant_vc_id_o;
    logic [VC_NUM-1:0]                    grant_onehot_o;
    logic                                 consume_vc_credit_vld_o;
    logic [VC_NUM_IDX_W-1:0]              consume_vc_credit_vc_id_o;
    logic                                 lock_vld_o;
    logic [VC_NUM_IDX_W-1:0]              lock_vc_id_o;

    modport master (
        output vc_req_vld_i, vc_req_tail_i, vc_credit_counter_i, out_ready_i,
        input  grant_vld_o, grant_vc_id_o, grant_onehot_o, consume_vc_credit_vld_o,
               consume_vc_credit_vc_id_o, lock_vld_o, lock_vc_id_o
    );

    modport slave (
        input  vc_req_vld_i, vc_req_tail_i, vc_credit_counter_i, out_ready_i,
        output grant_vld_o, grant_vc_id_o, grant_onehot_o, consume_vc_credit_vld_o,
               consume_vc_credit_vc_id_o, lock_vld_o, lock_vc_id_o
    );
endinterface

// File: rtl/output_port_vc_sched.sv
// Per-output-port VC scheduler.
// Picks one VC per cycle for the output link: round-robin among VCs with a ready flit and a
// non-zero downstream credit count, optionally holding the link on one VC from head to tail.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : slave side of output_port_vc_sched_if (requests, credits, ready in;
//          grant, credit-consume strobe and lock state out)
// The grant path is combinational; the round-robin pointer and lock state advance only
// when the grant is accepted by the link (fire).
module output_port_vc_sched #(
    parameter int unsigned VC_NUM             = 4,
    parameter int unsigned VC_NUM_IDX_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    parameter int unsigned VC_DEPTH           = 1,
    parameter int unsigned VC_DEPTH_COUNTER_W = $clog2(VC_DEPTH + 1),
    parameter bit          PKT_LOCK           = 1'b0
) (
    input logic                   clk,
    input logic                   rstn,
    output_port_vc_sched_if.slave bus
);
    typedef enum logic {
        StUnlocked = 1'b0,
        StLocked   = 1'b1
    } lock_state_e;

    lock_state_e             lock_state_q;
    logic [VC_NUM_IDX_W-1:0] lock_vc_id_q;
    logic [VC_NUM_IDX_W-1:0] rr_ptr_q;

    logic [VC_NUM-1:0]       elig;
    logic                    grant_vld;
    logic [VC_NUM_IDX_W-1:0] grant_id;
    logic                    fire;
    logic [VC_NUM_IDX_W-1:0] rr_next;

    // A VC is eligible with a flit waiting and at least one downstream credit.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < VC_NUM; i++) begin
            elig[i] = bus.vc_req_vld_i[i] &
                      (bus.vc_credit_counter_i[i*VC_DEPTH_COUNTER_W +: VC_DEPTH_COUNTER_W] != '0);
        end
    end

    // Locked: only the locked VC may go. Unlocked: first eligible VC at or after rr_ptr.
    always_comb begin
        int unsigned             idx;
        logic [VC_NUM_IDX_W-1:0] cand;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        cand      = '0;
        if (lock_state_q == StLocked) begin
            grant_vld = elig[lock_vc_id_q];
            grant_id  = grant_vld ? lock_vc_id_q : '0;
        end else begin
            for (int unsigned off = 0; off < VC_NUM; off++) begin
                idx = 32'(rr_ptr_q) + off;
                if (idx >= VC_NUM) begin
                    idx = idx - VC_NUM;
                end
                cand = VC_NUM_IDX_W'(idx);
                if (!grant_vld && elig[cand]) begin
                    grant_vld = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    assign fire    = grant_vld & bus.out_ready_i;
    // Explicit wrap so non-power-of-2 VC_NUM never leaves rr_ptr out of range.
    assign rr_next = (grant_id == VC_NUM_IDX_W'(VC_NUM - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        bus.grant_onehot_o = '0;
        if (grant_vld) begin
            bus.grant_onehot_o[grant_id] = 1'b1;
        end
    end

    assign bus.grant_vld_o               = grant_vld;
    assign bus.grant_vc_id_o             = grant_id;
    assign bus.consume_vc_credit_vld_o   = fire;
    assign bus.consume_vc_credit_vc_id_o = grant_id;
    assign bus.lock_vld_o                = (lock_state_q == StLocked);
    assign bus.lock_vc_id_o              = lock_vc_id_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q     <= '0;
            lock_state_q <= StUnlocked;
            lock_vc_id_q <= '0;
        end else if (fire) begin
            rr_ptr_q <= rr_next;
            if (PKT_LOCK) begin
                case (lock_state_q)
                    StUnlocked: begin
                        // A head that is also a tail is a single-flit packet: no lock.
                        if (!bus.vc_req_tail_i[grant_id]) begin
                            lock_state_q <= StLocked;
                            lock_vc_id_q <= grant_id;
                        end
                    end
                    StLocked: begin
                        if (bus.vc_req_tail_i[grant_id]) begin
                            lock_state_q <= StUnlocked;
                        end
                    end
                    default: lock_state_q <= StUnlocked;
                endcase
            end
        end
    end
endmodule
